// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryption core: 10-cycle key expansion, then 10 inverse rounds at one per cycle.
// Optional macro KEY_CACHE_EN keeps the expanded schedule and skips KEYGEN when the same key returns.
module aes_decrypt #(
  parameter int DONE_HOLD = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYGEN = 3'd1,
    INIT   = 3'd2,
    ROUND  = 3'd3,
    FIN    = 3'd4
  } fsm_t;

  fsm_t                fsm_r;
  logic [127:0]        state_r;
  logic [10:0][127:0]  rk_r;
  logic [3:0]          rnd_r;
  logic [127:0]        kprev_s;
  logic [127:0]        next_rk_s;
  logic [127:0]        unmix_s;
  logic [127:0]        round_out_s;
`ifdef KEY_CACHE_EN
  logic                cache_valid_r;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ t) : p;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), the core of both S-box directions.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(i), 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte (row r, column c) sits at index 4c+r; InvShiftRows takes it from column (c-r) mod 4.
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  // Returns {0e*a, 0b*a, 0d*a, 09*a} from one xtime chain.
  function automatic logic [31:0] mul_set(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [31:0] m0, m1, m2, m3;
    m0 = mul_set(w[31:24]);
    m1 = mul_set(w[23:16]);
    m2 = mul_set(w[15:8]);
    m3 = mul_set(w[7:0]);
    return {m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0],
            m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8],
            m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16],
            m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  // Shared round datapath: next key-schedule entry and next inverse-round state.
  always_comb begin
    kprev_s     = (rnd_r == 4'd0) ? rk_r[0] : rk_r[rnd_r - 4'd1];
    next_rk_s   = key_step(kprev_s, rnd_r);
    unmix_s     = inv_sub_shift(state_r) ^ rk_r[rnd_r];
    round_out_s = (rnd_r == 4'd0) ? unmix_s : inv_mix(unmix_s);
  end

  // Control FSM with registered outputs; rnd_r counts up in KEYGEN and down in ROUND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r         <= IDLE;
      state_r       <= 128'h0;
      rk_r          <= '0;
      rnd_r         <= 4'd0;
      plaintext     <= 128'h0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef KEY_CACHE_EN
      cache_valid_r <= 1'b0;
`endif
    end else begin
      case (fsm_r)
        IDLE: begin
          if (start) begin
            state_r <= ciphertext;
            rk_r[0] <= key;
            rnd_r   <= 4'd1;
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef KEY_CACHE_EN
            if (cache_valid_r && (key == rk_r[0])) begin
              fsm_r <= INIT;
            end else begin
              fsm_r         <= KEYGEN;
              cache_valid_r <= 1'b0;
            end
`else
            fsm_r <= KEYGEN;
`endif
          end else if (DONE_HOLD == 0) begin
            done <= 1'b0;
          end else begin
            done <= done;
          end
        end
        KEYGEN: begin
          rk_r[rnd_r] <= next_rk_s;
          if (rnd_r == 4'd10) begin
            fsm_r <= INIT;
          end else begin
            rnd_r <= rnd_r + 4'd1;
          end
        end
        INIT: begin
          state_r <= state_r ^ rk_r[10];
          rnd_r   <= 4'd9;
          fsm_r   <= ROUND;
        end
        ROUND: begin
          state_r <= round_out_s;
          if (rnd_r == 4'd0) begin
            fsm_r <= FIN;
          end else begin
            rnd_r <= rnd_r - 4'd1;
          end
        end
        FIN: begin
          plaintext <= state_r;
          busy      <= 1'b0;
          done      <= 1'b1;
          fsm_r     <= IDLE;
`ifdef KEY_CACHE_EN
          cache_valid_r <= 1'b1;
`endif
        end
        default: fsm_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt.sv
// Directed bench for aes_decrypt: FIPS-197 vectors, latency, ignored start, async reset, done hold.
module tb_aes_decrypt;
  logic         clk;
  logic         rst_n;
  logic         start0;
  logic         start1;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] plaintext0;
  logic [127:0] plaintext1;
  logic         busy0;
  logic         busy1;
  logic         done0;
  logic         done1;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] Z   = 128'h0;
`ifdef KEY_CACHE_EN
  localparam int LAT_HIT = 12;
`else
  localparam int LAT_HIT = 22;
`endif

  aes_decrypt #(.DONE_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ciphertext(ciphertext), .key(key),
    .plaintext(plaintext0), .busy(busy0), .done(done0)
  );

  aes_decrypt #(.DONE_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ciphertext(ciphertext), .key(key),
    .plaintext(plaintext1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic done_of(input int which);
    return (which == 0) ? done0 : done1;
  endfunction

  function automatic logic busy_of(input int which);
    return (which == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [127:0] pt_of(input int which);
    return (which == 0) ? plaintext0 : plaintext1;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 0) start0 = v;
    else start1 = v;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (E0). Returns at the done negedge.
  task automatic run_op(input int which, input logic [127:0] ct, input logic [127:0] k,
                        input logic [127:0] exp_pt, input int exp_lat, input int pulse_at,
                        input string tag);
    int   cnt;
    logic busy_ok;
    ciphertext = ct;
    key        = k;
    set_start(which, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(which, 1'b0);
    ciphertext = ~ct;
    key        = ~k;
    check({tag, "_done_cleared"}, {127'h0, done_of(which)}, Z);
    cnt     = 0;
    busy_ok = 1'b1;
    while (cnt < 40 && done_of(which) !== 1'b1) begin
      busy_ok = busy_ok & busy_of(which);
      if (pulse_at != 0 && cnt == pulse_at - 1) set_start(which, 1'b1);
      @(posedge clk);
      cnt++;
      @(negedge clk);
      set_start(which, 1'b0);
    end
    check({tag, "_latency"}, 128'(cnt), 128'(exp_lat));
    check({tag, "_plaintext"}, pt_of(which), exp_pt);
    check({tag, "_busy_during"}, {127'h0, busy_ok}, 128'h1);
    check({tag, "_busy_at_done"}, {127'h0, busy_of(which)}, Z);
  endtask

  initial begin
    int   extra;
    logic hold_ok;
    rst_n      = 1'b0;
    start0     = 1'b0;
    start1     = 1'b0;
    ciphertext = 128'h0;
    key        = 128'h0;
    repeat (3) @(negedge clk);
    check("reset_plaintext", plaintext0, Z);
    check("reset_busy", {127'h0, busy0}, Z);
    check("reset_done", {127'h0, done0}, Z);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, C1, K1, P1, 22, 0, "fips_c1");
    // Started in the done cycle: back-to-back acceptance; a start at cycle 5 must be ignored.
    run_op(0, C0, Z, Z, 22, 5, "zero_key_pulse");
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done0 === 1'b1) extra++;
    end
    check("zero_key_extra_done", 128'(extra), Z);
    run_op(0, C0, Z, Z, LAT_HIT, 0, "zero_key_repeat");
    run_op(0, C2, K2, P2, 22, 0, "fips_b");

    // Asynchronous reset in the middle of an operation.
    ciphertext = C1;
    key        = K1;
    start0     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    check("midop_busy_before_reset", {127'h0, busy0}, 128'h1);
    rst_n = 1'b0;
    #1;
    check("midop_reset_plaintext", plaintext0, Z);
    check("midop_reset_busy", {127'h0, busy0}, Z);
    check("midop_reset_done", {127'h0, done0}, Z);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, C1, K1, P1, 22, 0, "after_reset");

    // Held done on the DONE_HOLD=1 instance.
    run_op(1, C2, K2, P2, 22, 0, "hold_fips_b");
    hold_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      hold_ok = hold_ok & done1;
    end
    check("hold_done_50_cycles", {127'h0, hold_ok}, 128'h1);
    check("hold_plaintext_kept", plaintext1, P2);
    run_op(1, C1, K1, P1, 22, 0, "hold_restart");
    run_op(1, C0, Z, Z, 22, 0, "hold_back_to_back");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_decrypt.md
Name: aes_decrypt

Overview:
- Iterative AES-128 decryption core. It is the inverse-direction partner of the team's AES-128 encryption core.
- Accepts one 128-bit ciphertext and key per start, expands the key internally, and runs 10 inverse rounds at one round per cycle. It returns the plaintext.
- Sits beside the encryptor on the same datapath bus. The byte ordering is the same: byte 0 is bits [127:120], column-major state, as in FIPS-197.

Parameters:
- DONE_HOLD, 0. Selects the done behaviour:
  - 0: done is a 1-cycle pulse.
  - 1: done stays high until the next accepted start or reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- ciphertext  input  128  block to decrypt; captured on the accepted start edge.
- key  input  128  cipher key; captured on the accepted start edge.
- plaintext  output  128  result; valid when done=1, held until the next accepted start.
- busy  output  1  high from the cycle after an accepted start until done asserts.
- done  output  1  completion flag (see DONE_HOLD).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE. plaintext=0, busy=0, done=0. Round counter=0. Round-key registers=0.
  - Reset mid-operation aborts the operation; no partial result is visible.
- Accepted start: IDLE state with start=1 at a rising edge. That edge:
  - captures ciphertext into the state register;
  - captures key as rk[0];
  - sets busy=1 and clears done.
- start while busy=1 is ignored. Input changes after capture have no effect.
- FSM states: IDLE -> KEYGEN -> INIT -> ROUND -> FIN -> IDLE.
- KEYGEN, 10 cycles:
  - Cycle i (i=1..10) computes rk[i] from rk[i-1] with RotWord, SubWord (4 forward S-boxes) and Rcon[i] = 01,02,04,08,10,20,40,80,1b,36.
  - rk[0..10] are stored in 11x128 registers.
- INIT, 1 cycle: state <= state ^ rk[10]. Round counter r <= 9.
- ROUND, 10 cycles:
  - For r = 9 down to 1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]).
  - For r = 0: state <= InvSubBytes(InvShiftRows(state)) ^ rk[0], with no InvMixColumns.
  - r decrements each cycle. When r=0 completes, go to FIN.
- FIN, 1 cycle: plaintext <= state, busy <= 0, done <= 1, go to IDLE.
- Datapath resources:
  - 16 combinational inverse S-box lookups (FIPS-197 table).
  - InvMixColumns over GF(2^8) with polynomial 0x11b, coefficients 0e,0b,0d,09 via xtime chains.
- Latency:
  - Accepted start at edge E0 gives done=1 after edge E0+22. That is KEYGEN 10, INIT 1, ROUND 10, FIN 1.
  - Throughput is one block per 23 cycles. A start sampled in the done cycle is accepted, because the FSM is already in IDLE.
- DONE_HOLD=0: done drops on the next edge. DONE_HOLD=1: done stays high until the next accepted start or reset.
- Simultaneous start and done cycle: the new capture takes priority. done is cleared, while plaintext keeps its old value until the new FIN.

Optional Feature:
- KEY_CACHE_EN defined:
  - The core keeps rk[0..10] plus a valid bit after completion.
  - If the captured key equals the cached rk[0] and valid=1, KEYGEN is skipped; start goes directly to INIT. done then arrives after E0+12.
  - Reset clears the valid bit.
- Not defined: no cache and no compare logic. Every start runs KEYGEN, so latency is always 22.

Test Plan:
- Reset, then start with key 000102030405060708090a0b0c0d0e0f and ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff; done exactly 22 edges after the start edge; busy high for cycles 1-21.
- Key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734.
- All-zero key, ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e -> plaintext all zero. Pulse start again at cycle 5 -> ignored; only one done. With KEY_CACHE_EN, a second start with the same key gives done after 12 edges.
- Assert rst_n=0 at cycle 15 of an operation -> plaintext=0, busy=0, done=0 immediately. Start again afterwards -> correct result in 22 cycles.
- DONE_HOLD=1: done stays high for 50 idle cycles, then drops on the edge where the next start is accepted. Back-to-back start in the done cycle is accepted.
